// File: rtl/sdram_bus_bridge_if.sv
// sdram_bus_bridge_if: processor bus and controller request/ack signals of the SDRAM bridge.
interface sdram_bus_bridge_if #(parameter int ADDR_W = 21);
    logic              bus_stb;
    logic              bus_we;
    logic [1:0]        bus_sel;
    logic [ADDR_W:1]   bus_adr;
    logic [15:0]       bus_din;
    logic [15:0]       bus_dout;
    logic              bus_ack;
    logic              ctrl_wr_req;
    logic              ctrl_rd_req;
    logic              ctrl_wr_ack;
    logic              ctrl_rd_ack;
    logic [ADDR_W:0]   ctrl_addr;
    logic [15:0]       ctrl_din;
    logic [15:0]       ctrl_dout;
    logic              ctrl_init_done;
    logic              dqm_h;
    logic              dqm_l;
    logic              busy;
    modport slave (
        input  bus_stb, bus_we, bus_sel, bus_adr, bus_din, ctrl_wr_ack, ctrl_rd_ack, ctrl_dout, ctrl_init_done,
        output bus_dout, bus_ack, ctrl_wr_req, ctrl_rd_req, ctrl_addr, ctrl_din, dqm_h, dqm_l, busy
    );
    modport master (
        output bus_stb, bus_we, bus_sel, bus_adr, bus_din, ctrl_wr_ack, ctrl_rd_ack, ctrl_dout, ctrl_init_done,
        input  bus_dout, bus_ack, ctrl_wr_req, ctrl_rd_req, ctrl_addr, ctrl_din, dqm_h, dqm_l, busy
    );
endinterface

// File: rtl/sdram_bus_bridge.sv
// sdram_bus_bridge: one controller request per bus cycle, latched addr/data/mask, delayed registered bus ack.
// Optional single-entry read buffer enabled by defining SDRAM_RDBUF_EN.
module sdram_bus_bridge #(
    parameter int ACK_DLY = 2,
    parameter int ADDR_W  = 21
) (
    input logic clk_p,
    input logic sdram_reset,
    sdram_bus_bridge_if.slave b
);
    typedef enum logic [1:0] {IDLE, REQ, DLY, DONE} state_t;
    state_t state, state_n;
    logic [2:0]      cnt, cnt_n;
    logic            abort, abort_n;
    logic            we_q, dqm_h_q, dqm_l_q, ack_q, wr_req_q, rd_req_q;
    logic [ADDR_W:1] adr_q;
    logic [15:0]     din_q, dout_q;
    logic            accept, hit, ctrl_ack, rd_done;
    assign accept   = state == IDLE && b.bus_stb && b.ctrl_init_done;
    assign ctrl_ack = we_q ? b.ctrl_wr_ack : b.ctrl_rd_ack;
    assign rd_done  = state == REQ && !we_q && b.ctrl_rd_ack;
`ifdef SDRAM_RDBUF_EN
    logic            buf_valid;
    logic [ADDR_W:1] buf_addr;
    logic [15:0]     buf_data;
    assign hit = buf_valid && buf_addr == b.bus_adr && !b.bus_we;
    always_ff @(posedge clk_p or posedge sdram_reset)
        if (sdram_reset) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else if (rd_done) begin
            buf_valid <= 1'b1;
            buf_addr  <= adr_q;
            buf_data  <= b.ctrl_dout;
        end else if (accept && b.bus_we && b.bus_adr == buf_addr)
            buf_valid <= 1'b0;
`else
    assign hit = 1'b0;
`endif
    // An aborted cycle still runs to DONE so the controller handshake completes, but never acks the bus.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        abort_n = abort;
        case (state)
            IDLE: if (accept) begin
                state_n = hit ? DLY : REQ;
                cnt_n   = 3'd1;
                abort_n = 1'b0;
            end
            REQ: begin
                abort_n = abort | !b.bus_stb;
                if (ctrl_ack) begin
                    state_n = DLY;
                    cnt_n   = 3'(ACK_DLY - 1);
                end
            end
            DLY: begin
                abort_n = abort | !b.bus_stb;
                state_n = cnt == 3'd0 ? DONE : DLY;
                cnt_n   = cnt == 3'd0 ? cnt : cnt - 3'd1;
            end
            DONE: state_n = (abort || !b.bus_stb) ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk_p or posedge sdram_reset)
        if (sdram_reset) begin
            state    <= IDLE;
            cnt      <= '0;
            abort    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            din_q    <= '0;
            dout_q   <= '0;
            dqm_h_q  <= 1'b0;
            dqm_l_q  <= 1'b0;
            ack_q    <= 1'b0;
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            abort    <= abort_n;
            wr_req_q <= state_n == REQ && (accept ? b.bus_we : we_q);
            rd_req_q <= state_n == REQ && !(accept ? b.bus_we : we_q);
            ack_q    <= state_n == DONE && !abort_n && b.bus_stb;
            if (accept) begin
                we_q    <= b.bus_we;
                adr_q   <= b.bus_adr;
                din_q   <= b.bus_din;
                dqm_h_q <= b.bus_we & ~b.bus_sel[1];
                dqm_l_q <= b.bus_we & ~b.bus_sel[0];
            end
`ifdef SDRAM_RDBUF_EN
            if (accept && hit)
                dout_q <= buf_data;
`endif
            if (rd_done)
                dout_q <= b.ctrl_dout;
        end
    assign b.bus_dout    = dout_q;
    assign b.bus_ack     = ack_q;
    assign b.ctrl_wr_req = wr_req_q;
    assign b.ctrl_rd_req = rd_req_q;
    assign b.ctrl_addr   = {1'b0, adr_q};
    assign b.ctrl_din    = din_q;
    assign b.dqm_h       = dqm_h_q;
    assign b.dqm_l       = dqm_l_q;
    assign b.busy        = state != IDLE;
endmodule
